adder16_nibble_seq: RTL and testbench

Multi-cycle WIDTH-bit adder that reuses a single combinational 4-bit carry-lookahead slice (`bit4_adder`), one nibble per clock, least-significant nibble first. The slice's `carry_out` is registered and fed back as the next nibble's `carry_in`. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the area-optimised alternative to the fully unrolled 16-bit CLA.

---
 rtl/adder16_nibble_seq_if.sv | 46 ++++
 rtl/adder16_nibble_seq.sv | 146 ++++++++++++++
 tb/tb_adder16_nibble_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder16_nibble_seq_if.sv
// Handshake bundle for the nibble-serial adder: operand side (in_*),
// result side (out_*), plus the result fields and a busy flag.
// master = producer/consumer side, slave = the adder itself.
interface adder16_nibble_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ans;
    logic             carry_out;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ans,
        input  carry_out,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ans,
        output carry_out,
        output ovf,
        output busy
    );
endinterface

// File: rtl/adder16_nibble_seq.sv
// Nibble-serial WIDTH-bit adder. A single 4-bit carry-lookahead slice is
// reused once per clock, least-significant nibble first, with its carry
// registered and fed back into the next nibble. Valid/ready on both sides.
// WIDTH must be a multiple of 4 and at least 4.

// 4-bit carry-lookahead slice, purely combinational.
module bit4_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, flattened so no carry ripples through the slice.
    always_comb begin
        c    = '0;
        c[0] = carry_in;
        c[1] = g[0] | (p[0] & carry_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_in);
    end

    assign sum       = p ^ c[3:0];
    assign carry_out = c[4];
endmodule

// State table:
//   state  | meaning
//   S_IDLE | waiting for operands, in_ready high
//   S_RUN  | one nibble per edge through the slice
//   S_DONE | result presented, waiting for out_ready
module adder16_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder16_nibble_seq_if.slave   bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] ans_q;
    logic             carry_out_q;
    logic             ovf_q;

    logic             accept;
    logic             deliver;
    logic             last_nib;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_carry;

    assign accept   = (state_q == S_IDLE) && bus.in_valid;
    assign deliver  = (state_q == S_DONE) && bus.out_ready;
    assign last_nib = (idx_q == LAST_IDX);

    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4];

    bit4_adder u_slice (
        .a         (nib_a),
        .b         (nib_b),
        .carry_in  (carry_q),
        .sum       (nib_sum),
        .carry_out (nib_carry)
    );

    // Control FSM: IDLE -> RUN on accept, RUN -> DONE after the last nibble,
    // DONE -> IDLE when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept)   state_q <= S_RUN;
                S_RUN:   if (last_nib) state_q <= S_DONE;
                S_DONE:  if (deliver)  state_q <= S_IDLE;
                default:               state_q <= S_IDLE;
            endcase
        end
    end

    // Operand capture, nibble index and the carry fed back into the slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.carry_in;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            carry_q <= nib_carry;
            idx_q   <= idx_q + 1'b1;
        end
    end

    // Result registers: one sum nibble per RUN edge; the final carry and the
    // signed-overflow flag are taken on the last nibble and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (state_q == S_RUN) begin
            ans_q[{idx_q, 2'b00} +: 4] <= nib_sum;
            if (last_nib) begin
                carry_out_q <= nib_carry;
                ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                            && (nib_sum[3] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ans       = ans_q;
    assign bus.carry_out = carry_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adder16_nibble_seq.sv
// Bench for the nibble-serial adder: scoreboard of expected results pushed
// at accept, popped and compared at the output handshake.
module tb_adder16_nibble_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder16_nibble_seq_if #(.WIDTH(16)) bus();

    adder16_nibble_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] ans;
        logic        co;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   or_mode  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        exp_t        e;
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        e.ans = s[15:0];
        e.co = s[16];
        e.ovf = (a[15] == b[15]) && (s[15] != a[15]);
        e.acc_cyc = 0;
        return e;
    endfunction

    // out_ready: always high, random stalls, or held low
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: latency on rise, stability while held, compare at handshake
    logic        ov_seen = 1'b0;
    logic [15:0] held_ans;
    logic        held_co;
    logic        held_ovf;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_seen = 1'b0;
            end else if (bus.out_valid) begin
                if (!ov_seen) begin
                    ov_seen  = 1'b1;
                    held_ans = bus.ans;
                    held_co  = bus.carry_out;
                    held_ovf = bus.ovf;
                    if (sb.size() == 0) check_val("unexpected_result", 32'd1, 32'd0);
                    else check_val("latency", cyc - sb[0].acc_cyc, 32'd4);
                    check_val("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
                end else begin
                    check_val("hold_ans", {16'd0, bus.ans}, {16'd0, held_ans});
                    check_val("hold_co_ovf", {30'd0, bus.carry_out, bus.ovf}, {30'd0, held_co, held_ovf});
                end
                if (bus.out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val("ans", {16'd0, bus.ans}, {16'd0, e.ans});
                    check_val("carry_out", {31'd0, bus.carry_out}, {31'd0, e.co});
                    check_val("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
                    ov_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci);
        exp_t e;
        int   budget;
        budget = 0;
        @(posedge clk);
        #1;
        while (!bus.in_ready && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!bus.in_ready) begin
            check_val("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.a = a;
        bus.b = b;
        bus.carry_in = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e = model(a, b, ci);
        e.acc_cyc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.carry_in = 1'($urandom);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || bus.out_valid) && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_val("drain", sb.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_flags"}, {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
        check_val({tag, "_result"}, {14'd0, bus.carry_out, bus.ovf, bus.ans}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic add
        send(16'h1234, 16'h4321, 1'b0);
        wait_drain();

        // full ripple
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_drain();

        // signed overflow and carry_in
        send(16'h7FFF, 16'h0000, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        wait_drain();

        // in_valid pulse during RUN is ignored
        send(16'h1234, 16'h4321, 1'b0);
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        bus.carry_in = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_val("in_ready_run", {30'd0, bus.in_ready, bus.busy}, 32'b01);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_drain();

        // backpressure: hold out_ready low in DONE
        or_mode = 2;
        send(16'hFFFF, 16'h0001, 1'b0);
        budget = 0;
        while (!bus.out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_val("bp_reach_done", {31'd0, bus.out_valid}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            check_val("bp_hold_flags", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b101);
        end
        or_mode = 0;
        @(posedge clk);
        #2;
        check_val("bp_out_ready", {31'd0, bus.out_ready}, 32'd1);
        @(posedge clk);
        #2;
        check_val("bp_to_idle", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
        check_val("bp_sb_empty", sb.size(), 32'd0);

        // reset mid-RUN at idx 2
        send(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h00FF, 16'h0F0F, 1'b0);
        wait_drain();

        // randomised sweep with random stalls
        or_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        wait_drain();
        or_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
